// File: rtl/button_event_gen_pkg.sv
// button_event_gen_pkg: shared per-button state encoding and 50 MHz default timings.
package button_event_gen_pkg;
  typedef enum logic [2:0] {WAIT_REL, IDLE, COUNT, HELD, LOCK} btn_state_t;
  localparam int CNT_W_DEF = 28;
  localparam int LONG_CYCLES_DEF = 150_000_000;
  localparam int COMBO_CYCLES_DEF = 250_000_000;
endpackage

// File: rtl/button_event_gen_if.sv
// button_event_gen_if: debounced button levels in, one-cycle semantic events out.
interface button_event_gen_if;
  logic btn1_pressed;
  logic btn2_pressed;
  logic btn1_short;
  logic btn1_long;
  logic btn2_short;
  logic btn2_long;
  logic combo;
  modport master (
    output btn1_pressed, btn2_pressed,
    input  btn1_short, btn1_long, btn2_short, btn2_long, combo
  );
  modport slave (
    input  btn1_pressed, btn2_pressed,
    output btn1_short, btn1_long, btn2_short, btn2_long, combo
  );
endinterface

// File: rtl/button_event_gen_press_classifier.sv
// press_classifier: classifies one button's presses into short/long one-cycle pulses.
module press_classifier
  import button_event_gen_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pressed,
  input  logic lock,
  output logic short_p,
  output logic long_p
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LONG_CYCLES - 1);
  btn_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic short_n, long_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= WAIT_REL;
      cnt <= '0;
      short_p <= 1'b0;
      long_p <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      short_p <= short_n;
      long_p <= long_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    short_n = 1'b0;
    long_n = 1'b0;
    if (lock) begin
      state_n = LOCK;
      cnt_n = '0;
    end else
      case (state)
        WAIT_REL: state_n = pressed ? WAIT_REL : IDLE;
        IDLE: if (pressed) begin
          state_n = COUNT;
          cnt_n = CNT_W'(1);
        end
        COUNT: if (!pressed) begin
          short_n = 1'b1;
          state_n = IDLE;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
          long_n = cnt == LAST;
          state_n = cnt == LAST ? HELD : COUNT;
        end
        HELD: if (!pressed) begin
          state_n = IDLE;
          cnt_n = '0;
        end
        default: state_n = IDLE;
      endcase
  end
endmodule

// File: rtl/button_event_gen.sv
// button_event_gen: two press classifiers plus the combo-hold counter and lock that suppresses them.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int COMBO_CYCLES = COMBO_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  button_event_gen_if.slave bus
);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(COMBO_CYCLES);
  logic both, lock_q, lock_n, combo_n;
  logic [CNT_W-1:0] ccnt, ccnt_n;
  assign both = bus.btn1_pressed & bus.btn2_pressed;
  // Lock feeds the classifiers combinationally so both enter LOCK on the first overlap edge.
  assign lock_n = both | (lock_q & (bus.btn1_pressed | bus.btn2_pressed));
  assign ccnt_n = !both ? '0 : ccnt == CMAX ? ccnt : ccnt + 1'b1;
  assign combo_n = both && ccnt == CMAX - 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lock_q <= 1'b0;
      ccnt <= '0;
      bus.combo <= 1'b0;
    end else begin
      lock_q <= lock_n;
      ccnt <= ccnt_n;
      bus.combo <= combo_n;
    end
  press_classifier #(.LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)) u_btn1 (
    .clk(clk), .rst(rst), .pressed(bus.btn1_pressed), .lock(lock_n),
    .short_p(bus.btn1_short), .long_p(bus.btn1_long)
  );
  press_classifier #(.LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)) u_btn2 (
    .clk(clk), .rst(rst), .pressed(bus.btn2_pressed), .lock(lock_n),
    .short_p(bus.btn2_short), .long_p(bus.btn2_long)
  );
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: scenario and randomized checks against a run-length reference model.
module tb_button_event_gen;
  localparam int L = 8;
  localparam int C = 12;
  logic clk = 0;
  logic rst = 0;
  button_event_gen_if bus();
  button_event_gen #(.LONG_CYCLES(L), .COMBO_CYCLES(C), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  int pass_n = 0;
  int total_n = 0;
  bit arm [2];
  int run [2];
  bit lk;
  int cb;
  logic [4:0] exp_o;
  int ev [5];
  logic [4:0] o;
  function automatic logic [4:0] obs();
    return {bus.btn1_short, bus.btn1_long, bus.btn2_short, bus.btn2_long, bus.combo};
  endfunction
  task automatic model_reset();
    arm = '{0, 0};
    run = '{0, 0};
    lk = 0;
    cb = 0;
    exp_o = '0;
  endtask
  task automatic clear_ev();
    ev = '{default: 0};
  endtask
  // Model: run length of consecutive highs per button; arming needs a low sample after reset.
  task automatic step(input logic a, input logic b);
    logic p [2];
    logic nl;
    @(negedge clk);
    bus.btn1_pressed = a;
    bus.btn2_pressed = b;
    @(posedge clk);
    #1;
    p[0] = a;
    p[1] = b;
    nl = (a & b) | (lk & (a | b));
    exp_o = '0;
    for (int i = 0; i < 2; i++) begin
      if (nl) begin
        arm[i] = 1;
        run[i] = 0;
      end else if (!arm[i]) arm[i] = !p[i];
      else if (p[i]) begin
        run[i]++;
        if (run[i] == L) exp_o[3 - 2 * i] = 1'b1;
      end else begin
        if (run[i] > 0 && run[i] < L) exp_o[4 - 2 * i] = 1'b1;
        run[i] = 0;
      end
    end
    cb = (a & b) ? cb + 1 : 0;
    if (cb == C) exp_o[0] = 1'b1;
    lk = nl;
    o = obs();
    for (int k = 0; k < 5; k++) if (o[k]) ev[k]++;
  endtask
  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    #2 rst = 1;
    #1;
    total_n++;
    if (obs() !== 5'b0) $display("FAIL reset_outputs: got %b want 00000", obs());
    else pass_n++;
    release_reset();
  endtask

  task automatic test_short();
    clear_ev();
    step(0, 0);
    for (int c = 0; c < 6; c++) begin
      step(c >= 1 && c <= 3, 0);
      total_n++;
      if (obs() !== exp_o) $display("FAIL short_c%0d: got %b want %b", c, obs(), exp_o);
      else pass_n++;
      if (c == 4) begin
        total_n++;
        if (obs() !== 5'b10000) $display("FAIL short_latency: got %b want 10000", obs());
        else pass_n++;
      end
    end
    total_n++;
    if (ev[4] !== 1 || ev[3] !== 0) $display("FAIL short_count: got s=%0d l=%0d want s=1 l=0", ev[4], ev[3]);
    else pass_n++;
  endtask

  task automatic test_long();
    clear_ev();
    for (int c = 1; c <= 24; c++) begin
      step(c <= 20, 0);
      total_n++;
      if (obs() !== exp_o) $display("FAIL long_c%0d: got %b want %b", c, obs(), exp_o);
      else pass_n++;
      if (c == L) begin
        total_n++;
        if (obs() !== 5'b01000) $display("FAIL long_latency: got %b want 01000", obs());
        else pass_n++;
      end
    end
    total_n++;
    if (ev[3] !== 1 || ev[4] !== 0) $display("FAIL long_count: got l=%0d s=%0d want l=1 s=0", ev[3], ev[4]);
    else pass_n++;
  endtask

  task automatic test_boundary();
    for (int n = L - 1; n <= L; n++) begin
      clear_ev();
      for (int c = 0; c < n + 3; c++) begin
        step(c < n, 0);
        total_n++;
        if (obs() !== exp_o) $display("FAIL boundary_n%0d_c%0d: got %b want %b", n, c, obs(), exp_o);
        else pass_n++;
      end
      total_n++;
      if (ev[4] !== (n < L) || ev[3] !== (n == L))
        $display("FAIL boundary_n%0d: got s=%0d l=%0d want s=%0d l=%0d", n, ev[4], ev[3], n < L, n == L);
      else pass_n++;
    end
  endtask

  task automatic test_combo();
    logic a, b;
    clear_ev();
    for (int c = 0; c < 29; c++) begin
      a = c < 17 || c >= 27;
      b = (c >= 2 && c < 20) || (c >= 23 && c < 26);
      if (c >= 22) a = 0;
      step(a, b);
      total_n++;
      if (obs() !== exp_o) $display("FAIL combo_c%0d: got %b want %b", c, obs(), exp_o);
      else pass_n++;
      if (c == 2 + C - 1) begin
        total_n++;
        if (obs() !== 5'b00001) $display("FAIL combo_latency: got %b want 00001", obs());
        else pass_n++;
      end
    end
    total_n++;
    if (ev[0] !== 1 || ev[2] !== 1 || ev[1] + ev[3] + ev[4] !== 0)
      $display("FAIL combo_count: got c=%0d s2=%0d other=%0d want 1 1 0", ev[0], ev[2], ev[1] + ev[3] + ev[4]);
    else pass_n++;
  endtask

  task automatic test_held_reset();
    clear_ev();
    bus.btn2_pressed = 1;
    #1 rst = 1;
    release_reset();
    for (int c = 0; c < 16; c++) begin
      step(0, c < 10 || (c >= 11 && c < 14));
      total_n++;
      if (obs() !== exp_o) $display("FAIL held_reset_c%0d: got %b want %b", c, obs(), exp_o);
      else pass_n++;
    end
    total_n++;
    if (ev[2] !== 1 || ev[1] !== 0) $display("FAIL held_reset_count: got s=%0d l=%0d want s=1 l=0", ev[2], ev[1]);
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    clear_ev();
    repeat (L) step(1, 0);
    #1 rst = 1;
    #1;
    total_n++;
    if (obs() !== 5'b0) $display("FAIL reset_async: got %b want 00000", obs());
    else pass_n++;
    release_reset();
    clear_ev();
    for (int c = 0; c < 18; c++) begin
      step(c < 10 || (c >= 12 && c < 15), 0);
      total_n++;
      if (obs() !== exp_o) $display("FAIL reset_mid_c%0d: got %b want %b", c, obs(), exp_o);
      else pass_n++;
    end
    total_n++;
    if (ev[4] !== 1 || ev[3] !== 0) $display("FAIL reset_mid_count: got s=%0d l=%0d want s=1 l=0", ev[4], ev[3]);
    else pass_n++;
  endtask

  task automatic test_random();
    int len;
    logic a, b;
    for (int seg = 0; seg < 60; seg++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 16);
      for (int c = 0; c < len; c++) begin
        step(a, b);
        total_n++;
        if (obs() !== exp_o) $display("FAIL random_s%0d_c%0d: got %b want %b", seg, c, obs(), exp_o);
        else pass_n++;
      end
    end
  endtask

  initial begin
    bus.btn1_pressed = 0;
    bus.btn2_pressed = 0;
    test_reset();
    test_short();
    test_long();
    test_boundary();
    test_combo();
    test_held_reset();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
